// File: rtl/vedic_pkg.sv
// Shared constants and Vedic (Urdhva-Tiryagbhyam) partial-product helpers
// for the 8-bit dot-product accumulator.
package vedic_pkg;

    localparam int PROD_W        = 16;
    localparam int CNT_W         = 8;
    localparam int CNT_MAX       = 255;
    localparam int ACC_W_DEFAULT = 24;

    // The 2x2 base cell uses the vertical and crosswise partial products.
    function automatic logic [3:0] vedic_2x2(input logic [1:0] a, input logic [1:0] b);
        logic v0;
        logic x0;
        logic x1;
        logic v1;
        logic c1;
        v0 = a[0] & b[0];
        x0 = a[1] & b[0];
        x1 = a[0] & b[1];
        v1 = a[1] & b[1];
        c1 = x0 & x1;
        return {v1 & c1, v1 ^ c1, x0 ^ x1, v0};
    endfunction

    function automatic logic [7:0] vedic_4x4(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] ll;
        logic [3:0] hl;
        logic [3:0] lh;
        logic [3:0] hh;
        ll = vedic_2x2(a[1:0], b[1:0]);
        hl = vedic_2x2(a[3:2], b[1:0]);
        lh = vedic_2x2(a[1:0], b[3:2]);
        hh = vedic_2x2(a[3:2], b[3:2]);
        return {4'b0, ll} + {2'b0, hl, 2'b0} + {2'b0, lh, 2'b0} + {hh, 4'b0};
    endfunction

endpackage

// File: rtl/vedic_8x8.sv
// Combinational 8x8 unsigned Vedic multiplier built from four 4x4 Vedic blocks.
module vedic_8x8
    import vedic_pkg::*;
(
    input  logic [7:0]        a,
    input  logic [7:0]        b,
    output logic [PROD_W-1:0] p
);

    logic [7:0] ll;
    logic [7:0] hl;
    logic [7:0] lh;
    logic [7:0] hh;

    always_comb begin
        ll = vedic_4x4(a[3:0], b[3:0]);
        hl = vedic_4x4(a[7:4], b[3:0]);
        lh = vedic_4x4(a[3:0], b[7:4]);
        hh = vedic_4x4(a[7:4], b[7:4]);
        p  = {8'b0, ll} + {4'b0, hl, 4'b0} + {4'b0, lh, 4'b0} + {hh, 8'b0};
    end

endmodule

// File: rtl/vedic_dot8.sv
// Streaming unsigned 8-bit dot product: one registered operand stage (S1)
// feeding a wrapping accumulator with saturating element count and sticky overflow.
module vedic_dot8
    import vedic_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_a,
    input  logic [7:0]       in_b,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic [7:0]       out_count,
    output logic             out_ovf
);

    // Handshake: a beat transfers on a rising edge where valid && ready are both
    // high; valid/data hold while ready is low, and ready never waits on valid.

    logic             s1_valid_q, s1_valid_d;
    logic [7:0]       s1_a_q, s1_a_d;
    logic [7:0]       s1_b_q, s1_b_d;
    logic             s1_last_q, s1_last_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             first_q, first_d;
    logic             out_valid_q, out_valid_d;
    logic [ACC_W-1:0] out_sum_q, out_sum_d;
    logic [CNT_W-1:0] out_count_q, out_count_d;
    logic             out_ovf_q, out_ovf_d;

    logic [PROD_W-1:0] prod;
    logic              s1_advance;
    logic              in_xfer;
    logic [ACC_W-1:0]  acc_base;
    logic [ACC_W:0]    acc_sum;

    vedic_8x8 u_mul (
        .a (s1_a_q),
        .b (s1_b_q),
        .p (prod)
    );

    // A finished vector may only leave S1 if the result register can take it.
    assign s1_advance = s1_valid_q && !(s1_last_q && out_valid_q && !out_ready);
    assign in_ready   = !s1_valid_q || s1_advance;
    assign in_xfer    = in_valid && in_ready;

    assign acc_base = first_q ? '0 : acc_q;
    assign acc_sum  = {1'b0, acc_base} + {{(ACC_W + 1 - PROD_W){1'b0}}, prod};

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_a_d      = s1_a_q;
        s1_b_d      = s1_b_q;
        s1_last_d   = s1_last_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        first_d     = first_q;
        out_valid_d = out_valid_q;
        out_sum_d   = out_sum_q;
        out_count_d = out_count_q;
        out_ovf_d   = out_ovf_q;

        if (in_xfer) begin
            s1_valid_d = 1'b1;
            s1_a_d     = in_a;
            s1_b_d     = in_b;
            s1_last_d  = in_last;
        end else if (s1_advance) begin
            s1_valid_d = 1'b0;
        end

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (s1_advance) begin
            acc_d   = acc_sum[ACC_W-1:0];
            ovf_d   = (first_q ? 1'b0 : ovf_q) | acc_sum[ACC_W];
            first_d = s1_last_q;
            if (first_q) begin
                cnt_d = CNT_W'(1);
            end else if (cnt_q == CNT_W'(CNT_MAX)) begin
                cnt_d = cnt_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            if (s1_last_q) begin
                out_valid_d = 1'b1;
                out_sum_d   = acc_d;
                out_count_d = cnt_d;
                out_ovf_d   = ovf_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s1_last_q   <= 1'b0;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            first_q     <= 1'b1;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_count_q <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            s1_last_q   <= s1_last_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            first_q     <= first_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_count_q <= out_count_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_count = out_count_q;
    assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_vedic_dot8.sv
// Bench for vedic_dot8 at ACC_W=16: directed scenarios plus random vectors,
// checked by a scoreboard fed from a plain-arithmetic dot-product model.
module tb_vedic_dot8;

    localparam int ACC_W = 16;
    localparam int EXP_W = ACC_W + 9;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       in_a;
    logic [7:0]       in_b;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_sum;
    logic [7:0]       out_count;
    logic             out_ovf;

    vedic_dot8 #(.ACC_W(ACC_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_count (out_count),
        .out_ovf   (out_ovf)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Scoreboard: {ovf, count, sum} per completed vector
    logic [EXP_W-1:0] exp_q[$];
    longint           model_total = 0;
    int               model_cnt   = 0;
    bit               rdy_rand    = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_accept(input logic [7:0] a, input logic [7:0] b, input logic last);
        longint sum_mod;
        int     cnt_sat;
        bit     ovf;
        model_total += longint'(a) * longint'(b);
        model_cnt++;
        if (last) begin
            sum_mod = model_total % (longint'(1) << ACC_W);
            cnt_sat = (model_cnt > 255) ? 255 : model_cnt;
            ovf     = model_total > ((longint'(1) << ACC_W) - 1);
            exp_q.push_back({ovf, 8'(cnt_sat), ACC_W'(sum_mod)});
            model_total = 0;
            model_cnt   = 0;
        end
    endtask

    // Driver tasks (called at posedge + 1)
    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic last);
        int waited = 0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_last  = last;
        @(negedge clk);
        while (!in_ready && waited < 1000) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            check("send_timeout", 0, 1);
            in_valid = 1'b0;
            @(posedge clk);
            #1;
        end else begin
            @(posedge clk);
            #1;
            model_accept(a, b, last);
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        rst      = 1'b1;
        exp_q.delete();
        model_total = 0;
        model_cnt   = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        rdy_rand  = 0;
        out_ready = 1'b1;
        in_valid  = 1'b0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("drain_empty", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) begin
        #1;
        if (rdy_rand) out_ready = 1'($urandom_range(0, 1));
    end

    // Monitor: pops on every output transfer; checks hold while stalled
    bit               hold_prev = 0;
    logic [ACC_W-1:0] prev_sum;
    logic [7:0]       prev_count;
    logic             prev_ovf;

    always @(negedge clk) begin
        logic [EXP_W-1:0] e;
        if (rst) begin
            hold_prev = 0;
        end else begin
            if (hold_prev) begin
                check("hold_valid", out_valid, 1);
                check("hold_sum", out_sum, prev_sum);
                check("hold_count", out_count, prev_count);
                check("hold_ovf", out_ovf, prev_ovf);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("out_without_expect", exp_q.size(), 1);
                end else begin
                    e = exp_q.pop_front();
                    check("out_sum", out_sum, e[ACC_W-1:0]);
                    check("out_count", out_count, e[ACC_W+7:ACC_W]);
                    check("out_ovf", out_ovf, e[EXP_W-1]);
                end
            end
            hold_prev  = out_valid && !out_ready;
            prev_sum   = out_sum;
            prev_count = out_count;
            prev_ovf   = out_ovf;
        end
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_sum", out_sum, 0);
        check("rst_out_count", out_count, 0);
        check("rst_out_ovf", out_ovf, 0);
        @(posedge clk);
        #1;

        // Single 255x255 element with latency check
        out_ready = 1'b1;
        send(8'd255, 8'd255, 1'b1);
        in_valid = 1'b0;
        @(negedge clk);
        check("lat_edge1_valid", out_valid, 0);
        @(negedge clk);
        check("lat_edge2_valid", out_valid, 1);
        drain();

        // Back-to-back vectors
        send(8'd1, 8'd2, 1'b0);
        send(8'd3, 8'd4, 1'b0);
        send(8'd5, 8'd6, 1'b1);
        send(8'd7, 8'd7, 1'b1);
        drain();

        // Stall with held result, then a single-cycle consume
        out_ready = 1'b0;
        send(8'd1, 8'd1, 1'b1);
        send(8'd2, 8'd3, 1'b0);
        send(8'd4, 8'd5, 1'b1);
        in_valid = 1'b0;
        @(negedge clk);
        check("stall_in_ready", in_ready, 0);
        check("stall_sum_held", out_sum, 1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check("reload_valid", out_valid, 1);
        check("reload_sum", out_sum, 26);
        check("reload_in_ready", in_ready, 1);
        drain();

        // Overflow then clear on the next vector
        send(8'd255, 8'd255, 1'b0);
        send(8'd255, 8'd255, 1'b1);
        send(8'd1, 8'd1, 1'b1);
        drain();

        // Count saturation
        for (int i = 0; i < 300; i++) send(8'd1, 8'd1, 1'b0);
        send(8'd1, 8'd1, 1'b1);
        drain();

        // Reset mid-vector
        send(8'd9, 8'd9, 1'b0);
        send(8'd8, 8'd8, 1'b0);
        do_reset();
        @(negedge clk);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        send(8'd2, 8'd2, 1'b1);
        drain();

        // Random vectors with random backpressure and idle gaps
        rdy_rand = 1;
        for (int v = 0; v < 40; v++) begin
            int len;
            len = $urandom_range(1, 6);
            for (int i = 0; i < len; i++) begin
                send(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), i == len - 1);
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            end
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
